// File: rtl/reg_dump.sv
// reg_dump: debug read-out engine for the register file.
//
// On a start pulse it walks registers 0..REG_NUM-1 through one regfile read
// port and emits each one as an {addr,data} beat on a valid/ready stream.
// While busy=1 the read port belongs to this block.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, abort        begin a dump (ignored unless idle) / cancel a dump
//   re, raddr, rdata    regfile read port (rdata is combinational)
//   dout_valid/ready    beat handshake to the debug link
//   dout_addr/data/last beat payload; last marks register REG_NUM-1
//   busy                dump in progress
//   done                one-cycle pulse after the last beat is accepted
module reg_dump #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              re,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W-1:0] dout_addr,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              handshake;
  logic              at_last;

  assign handshake = dout_valid & dout_ready;
  assign at_last   = (idx_reg == LAST_IDX);

  // Read port and status flags are pure decodes of the state.
  assign re    = (state_reg == READ);
  assign raddr = re ? idx_reg : '0;
  assign busy  = (state_reg == READ) || (state_reg == SEND);
  assign done  = (state_reg == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = READ;
          idx_next   = '0;
        end
      end
      READ: begin
        if (abort) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          state_next = SEND;
        end
      end
      SEND: begin
        // Abort takes priority over a handshake in the same cycle.
        if (abort) begin
          state_next = IDLE;
          idx_next   = '0;
        end else if (handshake) begin
          if (at_last) begin
            state_next = DONE;
          end else begin
            state_next = READ;
            idx_next   = idx_reg + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        idx_next   = '0;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Beat register: loaded from the read port at the end of READ, held
  // through SEND until accepted or aborted. last is cleared together with
  // valid so it never shows outside an active beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_addr  <= '0;
      dout_data  <= '0;
      dout_last  <= 1'b0;
    end else begin
      if (state_reg == READ && !abort) begin
        dout_valid <= 1'b1;
        dout_addr  <= idx_reg;
        dout_data  <= rdata;
        dout_last  <= at_last;
      end else if (state_reg == SEND && (abort || handshake)) begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed bench for reg_dump with a transaction-level model.
// Main instance dumps 32 registers; a second instance is built with 4.
module tb_reg_dump;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst, start, abort, dout_ready;
  logic        re, dout_valid, dout_last, busy, done;
  logic [4:0]  raddr, dout_addr;
  logic [31:0] rdata, dout_data;

  logic        s_start, s_abort, s_ready;
  logic        s_re, s_valid, s_last, s_busy, s_done;
  logic [4:0]  s_raddr, s_addr;
  logic [31:0] s_rdata, s_data;

  logic [31:0] regs [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata   = regs[raddr];
  assign s_rdata = regs[s_raddr];

  reg_dump #(.DATA_W(32), .ADDR_W(5), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .re(re), .raddr(raddr), .rdata(rdata),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_addr(dout_addr), .dout_data(dout_data), .dout_last(dout_last),
    .busy(busy), .done(done)
  );

  reg_dump #(.DATA_W(32), .ADDR_W(5), .REG_NUM(4)) dut4 (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .re(s_re), .raddr(s_raddr), .rdata(s_rdata),
    .dout_valid(s_valid), .dout_ready(s_ready),
    .dout_addr(s_addr), .dout_data(s_data), .dout_last(s_last),
    .busy(s_busy), .done(s_done)
  );

  function automatic logic [31:0] ref_val(int k);
    return (k == 0) ? 32'h0 : 32'h1000_0000 + k;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_run: a dump is in progress; m_have: a beat is on the stream;
  // m_idx: register currently being handled; m_done: done pulse due.
  logic chk_en = 1'b0;
  logic m_run = 1'b0, m_have = 1'b0, m_done = 1'b0;
  int   m_idx = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0; m_have <= 1'b0; m_done <= 1'b0; m_idx <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_run) begin
      if (start) begin m_run <= 1'b1; m_idx <= 0; end
    end else if (abort) begin
      m_run <= 1'b0; m_have <= 1'b0;
    end else if (!m_have) begin
      m_have <= 1'b1;
    end else if (dout_ready) begin
      m_have <= 1'b0;
      if (m_idx == N - 1) begin m_run <= 1'b0; m_done <= 1'b1; end
      else m_idx <= m_idx + 1;
    end
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_re;
      exp_re = m_run && !m_have;
      chk("busy",  64'(busy),  64'(m_run));
      chk("re",    64'(re),    64'(exp_re));
      chk("raddr", 64'(raddr), exp_re ? 64'(m_idx) : 64'd0);
      chk("valid", 64'(dout_valid), 64'(m_have));
      chk("last",  64'(dout_last),  64'(m_have && m_idx == N - 1));
      chk("done",  64'(done),  64'(m_done));
      if (m_have) begin
        chk("addr", 64'(dout_addr), 64'(m_idx));
        chk("data", 64'(dout_data), 64'(ref_val(m_idx)));
      end
    end
  end

  // Transaction log and counters for the directed literal checks.
  int beat_cnt = 0, done_cnt = 0, last_cnt = 0;
  logic [4:0]  last_addr;
  logic [31:0] last_data, first_data;
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (beat_cnt == 0) first_data = dout_data;
      beat_cnt++;
      if (dout_last) begin last_cnt++; last_addr = dout_addr; last_data = dout_data; end
      $display("beat addr=%0d data=%08h last=%0b", dout_addr, dout_data, dout_last);
    end
    if (!rst && done) begin
      done_cnt++;
      $display("done pulse");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    beat_cnt = 0; done_cnt = 0; last_cnt = 0;
  endtask

  task automatic wait_read(input int a);
    int n = 0;
    while (!(re && raddr == 5'(a)) && n < 300) begin tick(); n++; end
    chk("wait_read", 64'(re && raddr == 5'(a)), 64'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 400) begin tick(); n++; end
    chk("wait_done", 64'(done), 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    int n;
    int s_beats, s_lasts, s_dones, s_max, s_n;
    logic [4:0] s_last_addr;
    for (int k = 0; k < 32; k++) regs[k] = ref_val(k);
    rst = 1'b1; start = 1'b0; abort = 1'b0; dout_ready = 1'b1;
    s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_outputs", {re, raddr, dout_valid, dout_addr, dout_data, dout_last, busy, done}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: full dump with ready held high
    clr_counts();
    pulse_start();
    wait_done(n);
    chk("t1_cycles", 64'(n + 1), 64'd65);
    tick();
    chk("t1_beats", 64'(beat_cnt), 64'd32);
    chk("t1_dones", 64'(done_cnt), 64'd1);
    chk("t1_lasts", 64'(last_cnt), 64'd1);
    chk("t1_last_addr", 64'(last_addr), 64'd31);
    chk("t1_last_data", 64'(last_data), 64'h1000_001F);
    chk("t1_first_data", 64'(first_data), 64'd0);

    // 2: stall beat 7 for five cycles
    clr_counts();
    pulse_start();
    wait_read(7);
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_stall", {dout_valid, re, 3'b0, dout_addr, dout_data}, {1'b1, 1'b0, 3'b0, 5'd7, 32'h1000_0007});
    end
    dout_ready = 1'b1;
    tick();
    chk("t2_next_read", {re, raddr}, {1'b1, 5'd8});
    wait_done(n);
    tick();
    chk("t2_beats", 64'(beat_cnt), 64'd32);

    // 3: abort during SEND of beat 12, then restart
    clr_counts();
    pulse_start();
    wait_read(12);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_after_abort", {busy, dout_valid, re}, 3'b000);
    tick(); tick(); tick();
    chk("t3_no_done", 64'(done_cnt), 64'd0);
    chk("t3_beats", 64'(beat_cnt), 64'd13);
    pulse_start();
    chk("t3_restart", {re, raddr}, {1'b1, 5'd0});
    tick();
    chk("t3_restart_beat", {dout_valid, dout_addr}, {1'b1, 5'd0});
    wait_done(n);
    tick();

    // 4: start pulses while busy and in DONE are ignored
    clr_counts();
    pulse_start();
    wait_read(3);
    pulse_start();
    wait_done(n);
    pulse_start();
    chk("t4_idle", {busy, re}, 2'b00);
    tick(); tick();
    chk("t4_still_idle", 64'(busy), 64'd0);
    chk("t4_beats", 64'(beat_cnt), 64'd32);
    chk("t4_dones", 64'(done_cnt), 64'd1);

    // 5: reset mid-dump with a beat on the stream
    pulse_start();
    wait_read(20);
    tick();
    chk("t5_valid_before", 64'(dout_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_outputs", {re, raddr, dout_valid, dout_addr, dout_data, dout_last, busy, done}, 64'd0);
    tick();
    chk("t5_idle", 64'(busy), 64'd0);

    // 6: REG_NUM=4 instance
    s_beats = 0; s_lasts = 0; s_dones = 0; s_max = 0; s_last_addr = '0;
    s_start = 1'b1; tick(); s_start = 1'b0;
    s_n = 1;
    while (!s_done && s_n < 60) begin
      if (s_re && int'(s_raddr) > s_max) s_max = int'(s_raddr);
      if (s_valid && s_ready) begin
        chk("t6_beat_addr", 64'(s_addr), 64'(s_beats));
        chk("t6_beat_data", 64'(s_data), 64'(ref_val(s_beats)));
        s_beats++;
        if (s_last) begin s_lasts++; s_last_addr = s_addr; end
        $display("small beat addr=%0d data=%08h last=%0b", s_addr, s_data, s_last);
      end
      tick();
      s_n++;
    end
    if (s_done) s_dones++;
    chk("t6_cycles", 64'(s_n), 64'd9);
    chk("t6_beats", 64'(s_beats), 64'd4);
    chk("t6_lasts", 64'(s_lasts), 64'd1);
    chk("t6_last_addr", 64'(s_last_addr), 64'd3);
    chk("t6_done", 64'(s_dones), 64'd1);
    chk("t6_max_raddr", 64'(s_max), 64'd3);
    tick();
    chk("t6_idle", {s_busy, s_done, s_valid}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
